// File: rtl/axis_width_pkg.sv
// Shared helpers for the AXI-Stream width down-converter.
// Beat-counter width and emission-order lane mapping.
package axis_width_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } dw_state_e;

    // Counter width never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Lane that is emitted at beat number cnt.
    function automatic int lane_idx(
        input int cnt,
        input int shrink,
        input int msb_first
    );
        return (msb_first != 0) ? (shrink - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/axis_width_down_keep_last_lane.sv
// Priority encoder: beat count of the last kept lane in emission order.
// Ports: keep_i lane mask, last_cnt_o beat index (0 when mask is empty).
module axis_keep_last_lane #(
    parameter int SHRINK    = 4,
    parameter int MSB_FIRST = 0,
    parameter int CW        = 2
) (
    input  logic [SHRINK-1:0] keep_i,
    output logic [CW-1:0]     last_cnt_o
);

    // Later writes win, so scan toward the lane emitted last.
    always_comb begin
        last_cnt_o = '0;
        if (MSB_FIRST != 0) begin
            for (int i = SHRINK - 1; i >= 0; i--) begin
                if (keep_i[i]) last_cnt_o = CW'(SHRINK - 1 - i);
            end
        end else begin
            for (int i = 0; i < SHRINK; i++) begin
                if (keep_i[i]) last_cnt_o = CW'(i);
            end
        end
    end

endmodule

// File: rtl/axis_width_down.sv
// AXI-Stream width down-converter: one WIDTH word -> SHRINK narrow beats.
// Ports: clk/rst, s_rx_* wide slave (tkeep with AXIS_WIDTH_DOWN_KEEP_EN),
// m_tx_* narrow master. Outputs come only from the holding register.
module axis_width_down
    import axis_width_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int SHRINK    = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         s_rx_tdata,
`ifdef AXIS_WIDTH_DOWN_KEEP_EN
    input  logic [SHRINK-1:0]        s_rx_tkeep,
`endif
    input  logic                     s_rx_tlast,
    input  logic                     s_rx_tvalid,
    output logic                     s_rx_tready,
    output logic [WIDTH/SHRINK-1:0]  m_tx_tdata,
    output logic                     m_tx_tlast,
    output logic                     m_tx_tvalid,
    input  logic                     m_tx_tready
);

    localparam int LW = WIDTH / SHRINK;
    localparam int CW = cnt_w(SHRINK);

    dw_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             last_q, last_d;
    logic             full;
    logic             last_beat;
    logic             rx_fire;
    logic             tx_fire;
    int               idx;

`ifdef AXIS_WIDTH_DOWN_KEEP_EN
    logic [SHRINK-1:0] keep_q, keep_d;
    logic [CW-1:0]     last_cnt;

    axis_keep_last_lane #(
        .SHRINK    (SHRINK),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_keep_last (
        .keep_i     (keep_q),
        .last_cnt_o (last_cnt)
    );

    assign last_beat = (cnt_q == last_cnt);
`else
    assign last_beat = (cnt_q == CW'(SHRINK - 1));
`endif

    assign full        = (state_q == BUSY);
    assign m_tx_tvalid = full;
    assign s_rx_tready = !full || (last_beat && m_tx_tready);
    assign rx_fire     = s_rx_tvalid && s_rx_tready;
    assign tx_fire     = full && m_tx_tready;
    assign m_tx_tlast  = full && last_q && last_beat;

    always_comb begin
        idx        = lane_idx(int'(cnt_q), SHRINK, MSB_FIRST);
        m_tx_tdata = '0;
        for (int i = 0; i < SHRINK; i++) begin
            if (i == idx) m_tx_tdata = hold_q[i*LW +: LW];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        last_d  = last_q;
`ifdef AXIS_WIDTH_DOWN_KEEP_EN
        keep_d  = keep_q;
`endif
        if (tx_fire) begin
            if (last_beat) begin
                cnt_d   = '0;
                state_d = EMPTY;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // A load can only coincide with the final beat, so it wins.
        if (rx_fire) begin
            state_d = BUSY;
            cnt_d   = '0;
            hold_d  = s_rx_tdata;
            last_d  = s_rx_tlast;
`ifdef AXIS_WIDTH_DOWN_KEEP_EN
            keep_d  = s_rx_tkeep;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
`ifdef AXIS_WIDTH_DOWN_KEEP_EN
            keep_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
`ifdef AXIS_WIDTH_DOWN_KEEP_EN
            keep_q  <= keep_d;
`endif
        end
    end

endmodule
